// File: rtl/frogger_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frogger_play_ctrl
// Description : Game-support core for the 16x16 LED Frogger board.
//               - LFSR-driven traffic generator for 14 car lanes
//               - victory (score) counter with a one-cycle mid-round reset
//               - life counter with game-over flag
//               - two active-low 7-segment digits (score, lives)
//               Optional build macro FROGGER_GAME_OVER_EN: when defined,
//               traffic freezes and victories are ignored once lives hit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module frogger_play_ctrl #(
    parameter int unsigned TICK_BASE   = 2_500_000,
    parameter int unsigned START_LIVES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         speed,
    input  logic               frog_at_top,
    input  logic               loss,
    output logic [15:0][15:0]  traffic,
    output logic               mid_reset,
    output logic [3:0]         lives,
    output logic               game_over,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX5
);

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [3:0]  LIVES_INIT = 4'(START_LIVES);
    localparam logic [3:0]  SCORE_MAX  = 4'd9;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [31:0]        tick_q,  tick_d;
    logic [15:0]        lfsr_q,  lfsr_d;
    logic [15:0][15:0]  traffic_q;
    logic [15:0]        traffic_d [16];
    logic               frog_prev_q;
    logic               mid_reset_q, mid_reset_d;
    logic [3:0]         score_q, score_d;
    logic [3:0]         lives_q, lives_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [31:0]        w_tick_limit;
    logic               w_tick_hit;
    logic               w_step;
    logic               w_victory;
    logic               w_game_over;
    logic               w_run;

    // Step period scales with (8 - speed); speed is read live so a change is
    // seen at the very next compare. ">=" recovers cleanly if the period
    // shrinks while the counter is already past the new terminal value.
    assign w_tick_limit = TICK_BASE * (32'd8 - 32'(speed));
    assign w_tick_hit   = (tick_q >= (w_tick_limit - 32'd1));

    assign w_game_over  = (lives_q == 4'd0);

`ifdef FROGGER_GAME_OVER_EN
    // Game frozen once the last life is gone; only reset restarts play.
    assign w_run = ~w_game_over;
`else
    assign w_run = 1'b1;
`endif

    assign w_step    = w_tick_hit & w_run;
    assign w_victory = frog_at_top & ~frog_prev_q & w_run;

    // Tick counter: wraps at the terminal count, producing a 1-cycle step.
    always_comb begin
        tick_d = tick_q + 32'd1;
        if (w_tick_hit) begin
            tick_d = 32'd0;
        end
    end

    // 16-bit Fibonacci LFSR, taps 16,14,13,11; a non-zero seed never reaches 0.
    always_comb begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // ------------------------------------------------------------------------
    // Lane generation. Rows 0 and 8 are safe zones and always stay empty.
    // Odd rows drive toward col 15 (new car enters col 0); even rows drive
    // toward col 0 (new car enters col 15). ANDing two LFSR bits gives ~25%.
    // ------------------------------------------------------------------------
    for (genvar r = 0; r < 16; r++) begin : g_lane
        localparam int TAP = (r + 3) % 16;
        if ((r == 0) || (r == 8)) begin : g_quiet
            assign traffic_d[r] = 16'd0;
        end else if ((r % 2) == 1) begin : g_east
            logic w_nb;
            assign w_nb         = lfsr_q[r] & lfsr_q[TAP];
            assign traffic_d[r] = w_step ? {traffic_q[r][14:0], w_nb}
                                         : traffic_q[r];
        end else begin : g_west
            logic w_nb;
            assign w_nb         = lfsr_q[r] & lfsr_q[TAP];
            assign traffic_d[r] = w_step ? {w_nb, traffic_q[r][15:1]}
                                         : traffic_q[r];
        end
    end

    // Score advances on each frog_at_top rising edge, wrapping 9 -> 0.
    always_comb begin
        mid_reset_d = w_victory;
        score_d     = score_q;
        if (w_victory) begin
            score_d = (score_q == SCORE_MAX) ? 4'd0 : score_q + 4'd1;
        end
    end

    // Life counter: each loss pulse removes one life, saturating at zero.
    // Independent of the victory path so coincident events both apply.
    always_comb begin
        lives_d = lives_q;
        if (loss && (lives_q != 4'd0)) begin
            lives_d = lives_q - 4'd1;
        end
    end

    // All game state registers; reset discards any partial tick count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q      <= 32'd0;
            lfsr_q      <= LFSR_SEED;
            traffic_q   <= '0;
            frog_prev_q <= 1'b0;
            mid_reset_q <= 1'b0;
            score_q     <= 4'd0;
            lives_q     <= LIVES_INIT;
        end else begin
            tick_q      <= tick_d;
            lfsr_q      <= lfsr_d;
            for (int r = 0; r < 16; r++) begin
                traffic_q[r] <= traffic_d[r];
            end
            frog_prev_q <= frog_at_top;
            mid_reset_q <= mid_reset_d;
            score_q     <= score_d;
            lives_q     <= lives_d;
        end
    end

    // ------------------------------------------------------------------------
    // 7-segment decode, active-low {g,f,e,d,c,b,a}; blank for non-digits.
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign traffic   = traffic_q;
    assign mid_reset = mid_reset_q;
    assign lives     = lives_q;
    assign game_over = w_game_over;
    assign HEX0      = seg7(score_q);
    assign HEX5      = seg7(lives_q);

endmodule
`default_nettype wire

// File: tb/tb_frogger_play_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frogger_play_ctrl
// Description : Self-checking bench for frogger_play_ctrl. A behavioural
//               model pushes the expected outputs for every clock edge into
//               a scoreboard queue; the directed sequence pops and compares
//               one entry per cycle and adds spot checks against constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frogger_play_ctrl;

    localparam int TB_TICK = 4;

    logic              clk;
    logic              reset;
    logic [2:0]        speed;
    logic              frog_at_top;
    logic              loss;
    logic [15:0][15:0] traffic;
    logic              mid_reset;
    logic [3:0]        lives;
    logic              game_over;
    logic [6:0]        HEX0;
    logic [6:0]        HEX5;

    int n_cmp = 0;
    int n_bad = 0;

    frogger_play_ctrl #(
        .TICK_BASE   (TB_TICK),
        .START_LIVES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .speed       (speed),
        .frog_at_top (frog_at_top),
        .loss        (loss),
        .traffic     (traffic),
        .mid_reset   (mid_reset),
        .lives       (lives),
        .game_over   (game_over),
        .HEX0        (HEX0),
        .HEX5        (HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    typedef struct {
        logic [255:0] trf;
        logic         mid;
        logic [3:0]   lv;
        logic         go;
        logic [6:0]   h0;
        logic [6:0]   h5;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- behavioural reference model ----------------
    int                m_cnt;
    logic [15:0]       m_lfsr;
    logic [15:0][15:0] m_trf;
    logic              m_prev;
    int                m_score;
    int                m_lives;
    logic              m_mid;

    always @(posedge clk) begin
        exp_t e;
        int   lim;
        bit   stp;
        bit   run;
        bit   edge_seen;
        logic nb;
        logic fb;
        if (reset) begin
            m_cnt   = 0;
            m_lfsr  = 16'hACE1;
            m_trf   = '0;
            m_prev  = 1'b0;
            m_score = 0;
            m_lives = 3;
            m_mid   = 1'b0;
        end else begin
            run = 1'b1;
`ifdef FROGGER_GAME_OVER_EN
            run = (m_lives != 0);
`endif
            lim = TB_TICK * (8 - int'(speed));
            stp = (m_cnt >= lim - 1);
            m_cnt = stp ? 0 : m_cnt + 1;
            if (stp && run) begin
                for (int r = 1; r < 16; r++) begin
                    if (r != 8) begin
                        nb = m_lfsr[r] & m_lfsr[(r + 3) % 16];
                        if (r % 2 == 1) m_trf[r] = {m_trf[r][14:0], nb};
                        else            m_trf[r] = {nb, m_trf[r][15:1]};
                    end
                end
            end
            fb = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
            m_lfsr = {fb, m_lfsr[15:1]};
            edge_seen = frog_at_top && !m_prev;
            m_prev = frog_at_top;
            m_mid = edge_seen && run;
            if (m_mid) m_score = (m_score == 9) ? 0 : m_score + 1;
            if (loss && m_lives > 0) m_lives = m_lives - 1;
        end
        e.trf = m_trf;
        e.mid = m_mid;
        e.lv  = 4'(m_lives);
        e.go  = (m_lives == 0);
        e.h0  = seg_tbl[m_score];
        e.h5  = seg_tbl[m_lives];
        sb_q.push_back(e);
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        chk("sb_entry", 256'(sb_q.size() != 0), 256'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("traffic",   traffic,   e.trf);
            chk("mid_reset", mid_reset, e.mid);
            chk("lives",     lives,     e.lv);
            chk("game_over", game_over, e.go);
            chk("HEX0",      HEX0,      e.h0);
            chk("HEX5",      HEX5,      e.h5);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int pulses;
        reset       = 1'b1;
        speed       = 3'd7;
        frog_at_top = 1'b0;
        loss        = 1'b0;

        // Reset held for 3 cycles
        repeat (3) cyc();
        chk("rst_traffic", traffic, 256'd0);
        chk("rst_hex0", HEX0, 7'b1000000);
        chk("rst_hex5", HEX5, 7'b0110000);
        chk("rst_lives", lives, 4'd3);
        chk("rst_mid", mid_reset, 1'b0);
        chk("rst_go", game_over, 1'b0);

        // Fastest traffic: a step every 4 cycles
        reset = 1'b0;
        repeat (40) cyc();
        chk("row0_empty", traffic[0], 16'd0);
        chk("row8_empty", traffic[8], 16'd0);

        // Slowest traffic after a mid-run reset: first step on cycle 32
        reset = 1'b1;
        speed = 3'd0;
        cyc();
        reset = 1'b0;
        repeat (31) cyc();
        chk("spd0_no_step_yet", traffic, 256'd0);
        repeat (9) cyc();

        // Mid speed: first step on cycle 16
        reset = 1'b1;
        speed = 3'd4;
        cyc();
        reset = 1'b0;
        repeat (15) cyc();
        chk("spd4_no_step_yet", traffic, 256'd0);
        repeat (10) cyc();

        // Speed change in flight
        speed = 3'd6;
        repeat (12) cyc();

        // Fresh game at full speed; frog_at_top held for 5 cycles
        reset = 1'b1;
        speed = 3'd7;
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        frog_at_top = 1'b1;
        pulses = 0;
        repeat (5) begin
            cyc();
            if (mid_reset === 1'b1) pulses++;
        end
        chk("one_mid_pulse", 256'(pulses), 256'd1);
        chk("score1_hex0", HEX0, 7'b1111001);
        frog_at_top = 1'b0;
        cyc();

        // Nine more crossings: score wraps back to 0
        for (int i = 0; i < 9; i++) begin
            frog_at_top = 1'b1;
            repeat (2) cyc();
            frog_at_top = 1'b0;
            repeat (2) cyc();
        end
        chk("score_wrap_hex0", HEX0, 7'b1000000);

        // Loss coincident with a victory edge: both apply
        loss        = 1'b1;
        frog_at_top = 1'b1;
        cyc();
        loss        = 1'b0;
        frog_at_top = 1'b0;
        chk("both_lives", lives, 4'd2);
        chk("both_mid", mid_reset, 1'b1);
        chk("both_hex0", HEX0, 7'b1111001);
        chk("both_hex5", HEX5, 7'b0100100);

        cyc();
        loss = 1'b1;
        cyc();
        loss = 1'b0;
        chk("lives1", lives, 4'd1);
        chk("go_not_yet", game_over, 1'b0);

        cyc();
        loss = 1'b1;
        cyc();
        loss = 1'b0;
        chk("lives0", lives, 4'd0);
        chk("go_set", game_over, 1'b1);
        chk("hex5_zero", HEX5, 7'b1000000);

        cyc();
        loss = 1'b1;
        cyc();
        loss = 1'b0;
        chk("lives_sat", lives, 4'd0);

        // Post game-over window with a victory edge in the middle
        repeat (50) cyc();
        frog_at_top = 1'b1;
        repeat (3) cyc();
        frog_at_top = 1'b0;
        repeat (47) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
